// File: rtl/dpi_stream_pkg.sv
// Shared types and helpers for the per-stream regex context wrapper.
package dpi_stream_pkg;

    localparam int unsigned SID_W_DEF   = 6;
    localparam int unsigned STATE_W_DEF = 11;
    localparam int unsigned COUNT_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_COMMIT = 3'd4
    } ctx_state_e;

    // Increment v by inc, clamping at max instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc,
                                            input logic [31:0] max);
        if (inc && (v < max)) return v + 32'd1;
        return v;
    endfunction

endpackage

// File: rtl/dpi_ctx_ram.sv
// 1R1W synchronous RAM; a read of the address being written returns the old contents.
module dpi_ctx_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6,
    parameter int unsigned W     = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/dpi_regex_engine.sv
// Single-pattern DFA engine ("dpi" substring search) with the standard engine port set.
module dpi_regex_engine #(
    parameter int unsigned STATE_W = 11,
    parameter int unsigned LAT     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         char_in,
    input  logic               char_in_vld,
    input  logic [STATE_W-1:0] state_in,
    input  logic               state_in_vld,
    output logic [STATE_W-1:0] state_out,
    output logic               accept_out
);

    localparam logic [STATE_W-1:0] S_D   = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_DP  = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_ACC = STATE_W'(3);

    logic [STATE_W-1:0] st;
    logic [STATE_W-1:0] nxt;
    logic [LAT-1:0]     acc_pipe;

    // Pattern has no self-overlap, so every mismatch restarts on 'd' or falls to 0.
    always_comb begin
        nxt = (char_in == "d") ? S_D : '0;
        if (st == S_D  && char_in == "p") nxt = S_DP;
        if (st == S_DP && char_in == "i") nxt = S_ACC;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= '0;
            acc_pipe <= '0;
        end else begin
            if (state_in_vld)     st <= state_in;
            else if (char_in_vld) st <= nxt;
            acc_pipe[0] <= char_in_vld && (nxt == S_ACC);
            for (int unsigned i = 1; i < LAT; i++) acc_pipe[i] <= acc_pipe[i-1];
        end
    end

    assign state_out  = st;
    assign accept_out = acc_pipe[LAT-1];

endmodule

// File: rtl/dpi_stream_regex_ctx.sv
// Per-stream DFA context save/restore around one regex engine, with match commit.
// Optional per-stream count RAM: define DPI_STREAM_COUNT_EN.
module dpi_stream_regex_ctx
    import dpi_stream_pkg::*;
#(
    parameter int unsigned NUM_STREAMS = 64,
    parameter int unsigned SID_W       = SID_W_DEF,
    parameter int unsigned STATE_W     = STATE_W_DEF,
    parameter int unsigned COUNT_W     = COUNT_W_DEF,
    parameter int unsigned ENGINE_LAT  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_state,
    input  logic [SID_W-1:0]   stream_id,
    input  logic               new_stream_id,
    input  logic               enable,
    input  logic [7:0]         char_in,
    input  logic               char_in_vld,
    input  logic               eop,
    output logic               in_ready,
    output logic               fired,
    output logic               done,
    output logic [SID_W-1:0]   done_sid,
    output logic               done_hit,
    output logic [COUNT_W-1:0] count,
    output logic               proto_err,
    input  logic [SID_W-1:0]   cnt_rd_sid,
    output logic [COUNT_W-1:0] cnt_rd_data
);

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    ctx_state_e         st;
    logic [SID_W-1:0]   sid_q;
    logic               new_q;
    logic               en_q;
    logic [2:0]         drain_cnt;
    logic               fired_q;
    logic [COUNT_W-1:0] count_q;
    logic               proto_q;

    logic [SID_W-1:0]   ram_rd_addr;
    logic [STATE_W-1:0] ram_rd_data;
    logic [STATE_W-1:0] eng_state_in;
    logic [STATE_W-1:0] eng_state_out;
    logic               eng_char_vld;
    logic               eng_accept;
    logic               commit_we;

    // Read is issued from IDLE so data is ready in LOAD; sid_q holds the address afterwards.
    assign ram_rd_addr  = (st == ST_IDLE) ? stream_id : sid_q;
    assign eng_state_in = new_q ? '0 : ram_rd_data;
    assign eng_char_vld = char_in_vld && (st == ST_RUN);
    assign commit_we    = (st == ST_COMMIT) && en_q;

    dpi_ctx_ram #(
        .DEPTH (NUM_STREAMS),
        .AW    (SID_W),
        .W     (STATE_W)
    ) u_state_ram (
        .clk     (clk),
        .we      (commit_we),
        .wr_addr (sid_q),
        .wr_data (eng_state_out),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    dpi_regex_engine #(
        .STATE_W (STATE_W),
        .LAT     (ENGINE_LAT)
    ) u_engine (
        .clk          (clk),
        .rst          (rst),
        .char_in      (char_in),
        .char_in_vld  (eng_char_vld),
        .state_in     (eng_state_in),
        .state_in_vld (st == ST_LOAD),
        .state_out    (eng_state_out),
        .accept_out   (eng_accept)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= ST_IDLE;
            sid_q     <= '0;
            new_q     <= 1'b0;
            en_q      <= 1'b0;
            drain_cnt <= '0;
            fired_q   <= 1'b0;
            count_q   <= '0;
            proto_q   <= 1'b0;
        end else begin
            if (load_state && (st != ST_IDLE))            proto_q <= 1'b1;
            if ((char_in_vld || eop) && (st != ST_RUN))   proto_q <= 1'b1;
            if (eng_accept && (st == ST_RUN || st == ST_DRAIN)) fired_q <= 1'b1;

            case (st)
                ST_IDLE: begin
                    if (load_state) begin
                        sid_q   <= stream_id;
                        new_q   <= new_stream_id;
                        en_q    <= enable;
                        fired_q <= 1'b0;
                        st      <= ST_LOAD;
                    end
                end
                ST_LOAD: st <= ST_RUN;
                ST_RUN: begin
                    if (eop) begin
                        drain_cnt <= 3'(ENGINE_LAT - 1);
                        st        <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) st <= ST_COMMIT;
                    else                 drain_cnt <= drain_cnt - 3'd1;
                end
                ST_COMMIT: begin
                    st <= ST_IDLE;
                    if (en_q) count_q <= COUNT_W'(sat_inc(32'(count_q), fired_q, 32'(CNT_MAX)));
                    else      fired_q <= 1'b0;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

`ifdef DPI_STREAM_COUNT_EN
    logic [COUNT_W-1:0] cnt_cur;
    logic [COUNT_W-1:0] cnt_base;
    logic [COUNT_W-1:0] cnt_wr;

    assign cnt_base = new_q ? '0 : cnt_cur;
    assign cnt_wr   = COUNT_W'(sat_inc(32'(cnt_base), fired_q, 32'(CNT_MAX)));

    // Two copies share every write: one feeds the commit update, one the external read port.
    dpi_ctx_ram #(
        .DEPTH (NUM_STREAMS),
        .AW    (SID_W),
        .W     (COUNT_W)
    ) u_cnt_ram_upd (
        .clk     (clk),
        .we      (commit_we),
        .wr_addr (sid_q),
        .wr_data (cnt_wr),
        .rd_addr (sid_q),
        .rd_data (cnt_cur)
    );

    dpi_ctx_ram #(
        .DEPTH (NUM_STREAMS),
        .AW    (SID_W),
        .W     (COUNT_W)
    ) u_cnt_ram_rd (
        .clk     (clk),
        .we      (commit_we),
        .wr_addr (sid_q),
        .wr_data (cnt_wr),
        .rd_addr (cnt_rd_sid),
        .rd_data (cnt_rd_data)
    );
`else
    logic unused_cnt_rd;
    assign unused_cnt_rd = ^cnt_rd_sid;
    assign cnt_rd_data   = '0;
`endif

    assign in_ready  = (st == ST_RUN);
    assign fired     = fired_q;
    assign done      = (st == ST_COMMIT);
    assign done_sid  = sid_q;
    assign done_hit  = (st == ST_COMMIT) && en_q && fired_q;
    assign count     = count_q;
    assign proto_err = proto_q;

endmodule

// File: tb/tb_dpi_stream_regex_ctx.sv
// Bench for dpi_stream_regex_ctx: directed and random packets against a byte-history model.
module tb_dpi_stream_regex_ctx;

    localparam int unsigned SID_W   = 6;
    localparam int unsigned COUNT_W = 4;
    localparam int unsigned LAT     = 1;
    localparam int unsigned CMAX    = (1 << COUNT_W) - 1;

    logic               clk;
    logic               rst;
    logic               load_state;
    logic [SID_W-1:0]   stream_id;
    logic               new_stream_id;
    logic               enable;
    logic [7:0]         char_in;
    logic               char_in_vld;
    logic               eop;
    logic               in_ready;
    logic               fired;
    logic               done;
    logic [SID_W-1:0]   done_sid;
    logic               done_hit;
    logic [COUNT_W-1:0] count;
    logic               proto_err;
    logic [SID_W-1:0]   cnt_rd_sid;
    logic [COUNT_W-1:0] cnt_rd_data;

    dpi_stream_regex_ctx #(
        .NUM_STREAMS (64),
        .SID_W       (SID_W),
        .STATE_W     (11),
        .COUNT_W     (COUNT_W),
        .ENGINE_LAT  (LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_state    (load_state),
        .stream_id     (stream_id),
        .new_stream_id (new_stream_id),
        .enable        (enable),
        .char_in       (char_in),
        .char_in_vld   (char_in_vld),
        .eop           (eop),
        .in_ready      (in_ready),
        .fired         (fired),
        .done          (done),
        .done_sid      (done_sid),
        .done_hit      (done_hit),
        .count         (count),
        .proto_err     (proto_err),
        .cnt_rd_sid    (cnt_rd_sid),
        .cnt_rd_data   (cnt_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_asserts = 0;
    int          n_fails   = 0;
    byte         hist [64][$];
    int unsigned cnt_m [64];
    int unsigned count_m = 0;
    bit          used [64];
    byte         pkt [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input string s);
        pkt.delete();
        for (int i = 0; i < s.len(); i++) pkt.push_back(s[i]);
    endtask

    function automatic int unsigned sat(input int unsigned v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Stream history = bytes seen so far; a match is "dpi" ending at any byte of this packet.
    task automatic model_packet(input int sid, input bit nw, input bit en, output bit hit);
        byte h[$];
        hit = 1'b0;
        if (!nw) h = hist[sid];
        foreach (pkt[i]) begin
            h.push_back(pkt[i]);
            if (h.size() >= 3 && h[h.size()-3] == "d" && h[h.size()-2] == "p" && h[h.size()-1] == "i")
                hit = 1'b1;
            while (h.size() > 2) void'(h.pop_front());
        end
        if (en) begin
            hist[sid]  = h;
            count_m    = sat(count_m + hit);
            cnt_m[sid] = sat((nw ? 0 : cnt_m[sid]) + hit);
            used[sid]  = 1'b1;
        end
    endtask

    task automatic run_packet(input int sid, input bit nw, input bit en,
                              input bit chk_ready, input bit inj_load);
        bit hit;
        int w;
        model_packet(sid, nw, en, hit);
        load_state    = 1'b1;
        stream_id     = SID_W'(sid);
        new_stream_id = nw;
        enable        = en;
        step();
        load_state = 1'b0;
        if (chk_ready) check("ready_in_load", 32'(in_ready), 32'd0);
        step();
        if (chk_ready) check("ready_in_run", 32'(in_ready), 32'd1);
        if (inj_load) begin
            load_state = 1'b1;
            stream_id  = SID_W'(sid + 1);
            step();
            load_state = 1'b0;
            check("proto_load_in_run", 32'(proto_err), 32'd1);
        end
        foreach (pkt[i]) begin
            char_in     = pkt[i];
            char_in_vld = 1'b1;
            eop         = (i == pkt.size() - 1);
            step();
        end
        char_in_vld = 1'b0;
        eop         = 1'b0;
        w = 0;
        while (!done && w < 8) begin
            step();
            w++;
        end
        check("eop_to_done", 32'(w), 32'(LAT));
        check("done_sid", 32'(done_sid), 32'(sid));
        check("done_hit", 32'(done_hit), 32'(hit && en));
        check("fired_at_done", 32'(fired), 32'(hit));
        step();
        check("done_strobe_len", 32'(done), 32'd0);
        check("count", 32'(count), 32'(count_m));
        check("fired_after", 32'(fired), 32'(en && hit));
`ifdef DPI_STREAM_COUNT_EN
        cnt_rd_sid = SID_W'(sid);
        step();
        check("cnt_rd_data", 32'(cnt_rd_data), 32'(cnt_m[sid]));
`else
        check("cnt_rd_tied", 32'(cnt_rd_data), 32'd0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        string alpha;
        alpha         = "dpix";
        rst           = 1'b1;
        load_state    = 1'b0;
        stream_id     = '0;
        new_stream_id = 1'b0;
        enable        = 1'b0;
        char_in       = '0;
        char_in_vld   = 1'b0;
        eop           = 1'b0;
        cnt_rd_sid    = '0;
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_fired", 32'(fired), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_sid", 32'(done_sid), 32'd0);
        check("rst_done_hit", 32'(done_hit), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        rst = 1'b0;
        step();

        // 1: new stream 3, match ending on byte 5 of 20
        set_pkt("xxdpixxxxxxxxxxxxxxx");
        run_packet(3, 1'b1, 1'b1, 1'b1, 1'b0);
        // 2: pattern split across two packets of stream 3
        set_pkt("xxd");
        run_packet(3, 1'b0, 1'b1, 1'b0, 1'b0);
        set_pkt("pix");
        run_packet(3, 1'b0, 1'b1, 1'b0, 1'b0);
        // 3: disabled packet matches but must not save state or count
        set_pkt("xxdp");
        run_packet(7, 1'b1, 1'b1, 1'b0, 1'b0);
        set_pkt("ixx");
        run_packet(7, 1'b0, 1'b0, 1'b0, 1'b0);
        set_pkt("i");
        run_packet(7, 1'b0, 1'b1, 1'b0, 1'b0);

        // random packets across a few streams
        for (int p = 0; p < 25; p++) begin
            int sid;
            bit nw;
            bit en;
            int len;
            sid = int'($urandom_range(7, 0));
            en  = ($urandom_range(3, 0) != 0);
            nw  = !used[sid] || ($urandom_range(3, 0) == 0);
            len = int'($urandom_range(12, 1));
            pkt.delete();
            for (int i = 0; i < len; i++) pkt.push_back(alpha[$urandom_range(3, 0)]);
            run_packet(sid, nw, en, 1'b0, 1'b0);
            for (int g = int'($urandom_range(2, 0)); g > 0; g--) step();
        end

        // 4: protocol violations are ignored but sticky
        check("proto_before", 32'(proto_err), 32'd0);
        char_in     = "d";
        char_in_vld = 1'b1;
        step();
        char_in_vld = 1'b0;
        check("proto_char_idle", 32'(proto_err), 32'd1);
        check("ready_after_char_idle", 32'(in_ready), 32'd0);
        set_pkt("xpix");
        run_packet(12, 1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_m = 0;
        check("proto_cleared_by_rst", 32'(proto_err), 32'd0);
        set_pkt("dpix");
        run_packet(10, 1'b1, 1'b1, 1'b0, 1'b1);
        check("proto_sticky", 32'(proto_err), 32'd1);

        // 6: reset during DRAIN after a match discards the packet
        load_state    = 1'b1;
        stream_id     = SID_W'(5);
        new_stream_id = 1'b1;
        enable        = 1'b1;
        step();
        load_state = 1'b0;
        step();
        set_pkt("dpi");
        foreach (pkt[i]) begin
            char_in     = pkt[i];
            char_in_vld = 1'b1;
            eop         = (i == pkt.size() - 1);
            step();
        end
        char_in_vld = 1'b0;
        eop         = 1'b0;
        rst         = 1'b1;
        step();
        rst     = 1'b0;
        count_m = 0;
        check("drain_rst_done", 32'(done), 32'd0);
        check("drain_rst_count", 32'(count), 32'd0);
        check("drain_rst_fired", 32'(fired), 32'd0);
        check("drain_rst_ready", 32'(in_ready), 32'd0);
        step();
        check("drain_rst_no_late_done", 32'(done), 32'd0);
        set_pkt("dpi");
        run_packet(5, 1'b1, 1'b1, 1'b1, 1'b0);

        // 5: 17 matching packets saturate the count
        rst = 1'b1;
        step();
        rst     = 1'b0;
        count_m = 0;
        set_pkt("dpi");
        for (int p = 0; p < 17; p++) run_packet(9, (p == 0), 1'b1, 1'b0, 1'b0);
        check("count_saturated", 32'(count), 32'(CMAX));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
